// File: rtl/mem_access.sv
// mem_access: memory-access stage between EX/MEM and MEM/WB.
// Non-memory ops pass straight through. Loads and stores run one req/ack
// bus transaction under a three-state FSM that holds stallreq until the
// result is ready. Lanes are big-endian (addr[1:0]==0 is bits 31:24).
// Optional feature macro: MISALIGN_CHECK_EN. When defined, misaligned
// halfword/word accesses are flagged and suppressed. When undefined,
// the low address bits are forced aligned and the access proceeds.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_rw,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    output logic [4:0]  wb_rw,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        misalign
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic        is_load, is_store, sz_byte, sz_half, sz_word, ld_signed;
    logic        mis_raw, mem_go;
    logic [31:0] addr_eff;
    logic [3:0]  sel_c;
    logic [31:0] sdata_c;
    logic [31:0] rdata_q;

    // Pick the lane of the captured read word and sign/zero extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  a,
                                             input logic        is_byte,
                                             input logic        is_half,
                                             input logic        sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        case (a)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = a[1] ? word[15:0] : word[31:16];
        if (is_byte) begin
            if (sgn) begin
                r = b;
            end else begin
                r = {24'd0, b};
            end
        end else if (is_half) begin
            if (sgn) begin
                r = h;
            end else begin
                r = {16'd0, h};
            end
        end else begin
            r = word;
        end
        return r;
    endfunction

    // Decode the operation into direction, access size and signedness.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        sz_byte   = 1'b0;
        sz_half   = 1'b0;
        sz_word   = 1'b0;
        ld_signed = 1'b0;
        case (mem_aluop)
            OP_LB:   begin is_load = 1'b1;  sz_byte = 1'b1; ld_signed = 1'b1; end
            OP_LBU:  begin is_load = 1'b1;  sz_byte = 1'b1; end
            OP_LH:   begin is_load = 1'b1;  sz_half = 1'b1; ld_signed = 1'b1; end
            OP_LHU:  begin is_load = 1'b1;  sz_half = 1'b1; end
            OP_LW:   begin is_load = 1'b1;  sz_word = 1'b1; end
            OP_SB:   begin is_store = 1'b1; sz_byte = 1'b1; end
            OP_SH:   begin is_store = 1'b1; sz_half = 1'b1; end
            OP_SW:   begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

    // Alignment handling, lane enables and replicated store data.
    always_comb begin
        addr_eff = mem_addr;
`ifdef MISALIGN_CHECK_EN
        mis_raw = (sz_half & mem_addr[0]) | (sz_word & (mem_addr[1:0] != 2'b00));
`else
        mis_raw = 1'b0;
        if (sz_half) addr_eff[0] = 1'b0;
        if (sz_word) addr_eff[1:0] = 2'b00;
`endif
        mem_go  = (is_load | is_store) & ~mis_raw;
        sel_c   = 4'b1111;
        sdata_c = mem_sdata;
        if (sz_byte) begin
            sel_c   = 4'b1000 >> addr_eff[1:0];
            sdata_c = {4{mem_sdata[7:0]}};
        end else if (sz_half) begin
            sel_c   = addr_eff[1] ? 4'b0011 : 4'b1100;
            sdata_c = {2{mem_sdata[15:0]}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and stall request.
    always_comb begin
        state_nx = state;
        stallreq = 1'b0;
        case (state)
            IDLE:    if (mem_go)  state_nx = BUSY;
            BUSY:    if (bus_ack) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (!rst && mem_go && state != DONE) stallreq = 1'b1;
    end

    // Bus request fields: loaded on transaction start, held until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
            rdata_q   <= 32'd0;
        end else if (state == IDLE && mem_go) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {addr_eff[31:2], 2'b00};
            bus_sel   <= sel_c;
            bus_wdata <= sdata_c;
        end else if (state == BUSY && bus_ack) begin
            bus_req   <= 1'b0;
            rdata_q   <= bus_rdata;
        end
    end

    // Write-back mux: pass-through, load result, or store/misalign squash.
    always_comb begin
        wb_rw    = mem_rw;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        wb_whilo = mem_whilo;
        wb_hi    = mem_hi;
        wb_lo    = mem_lo;
        if (is_load && !mis_raw) begin
            wb_wdata = load_ext(rdata_q, addr_eff[1:0], sz_byte, sz_half, ld_signed);
        end
        if (is_store || mis_raw) wb_wreg = 1'b0;
        if (rst) begin
            wb_rw    = 5'd0;
            wb_wreg  = 1'b0;
            wb_wdata = 32'd0;
            wb_whilo = 1'b0;
            wb_hi    = 32'd0;
            wb_lo    = 32'd0;
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign misalign = ~rst & mis_raw;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector tables for pass-through and
// memory transactions, plus hand sequences for reset and alignment.
module tb_mem_access;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_rw;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr, mem_sdata;
    logic [4:0]  wb_rw;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo;
    logic        stallreq, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack, misalign;

    int checks = 0;
    int errors = 0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_rw(mem_rw), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .wb_rw(wb_rw), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .stallreq(stallreq), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [4:0]  rw;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  e_rw;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_whilo;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } pvec_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic        e_we;
        logic [31:0] e_bwdata;
        logic [31:0] e_wdata;
        logic        e_wreg;
        int          e_stall;
    } mvec_t;

    pvec_t pv[3];
    mvec_t mv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        mem_aluop = 8'h00; mem_rw = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
        mem_whilo = 1'b0; mem_hi = 32'd0; mem_lo = 32'd0;
        mem_addr = 32'd0; mem_sdata = 32'd0;
    endtask

    // One memory op from arrival to its DONE cycle; ack after v.delay BUSY cycles.
    task automatic run_mem(input mvec_t v);
        int stalls = 0;
        for (int k = 0; k <= v.delay + 2; k++) begin
            next_cycle();
            if (k == 0) begin
                mem_aluop = v.op; mem_addr = v.addr; mem_sdata = v.sdata;
                mem_rw = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h0BAD_F00D;
            end
            bus_ack   = (k == v.delay + 1);
            bus_rdata = bus_ack ? v.rdata : 32'h5A5A_5A5A;
            #1;
            if (stallreq) stalls++;
            if (k >= 1 && k <= v.delay + 1) begin
                chk("busy_req", {31'd0, bus_req}, 32'd1);
                chk("busy_addr", bus_addr, v.e_addr);
                chk("busy_sel", {28'd0, bus_sel}, {28'd0, v.e_sel});
                chk("busy_we", {31'd0, bus_we}, {31'd0, v.e_we});
                if (v.e_we) chk("busy_wdata", bus_wdata, v.e_bwdata);
            end
            if (k == v.delay + 2) begin
                chk("done_stall", {31'd0, stallreq}, 32'd0);
                chk("done_req", {31'd0, bus_req}, 32'd0);
                chk("done_wreg", {31'd0, wb_wreg}, {31'd0, v.e_wreg});
                chk("done_rw", {27'd0, wb_rw}, 32'd7);
                if (v.e_wreg) chk("done_wdata", wb_wdata, v.e_wdata);
            end
        end
        chk("stall_cycles", stalls, v.e_stall);
    endtask

    initial begin
        mvec_t ma;

        pv[0] = '{8'h20, 5'd5,  1'b1, 32'h1234_5678, 1'b0, 32'd0, 32'd0,
                  5'd5,  1'b1, 32'h1234_5678, 1'b0, 32'd0, 32'd0};
        pv[1] = '{8'h18, 5'd0,  1'b0, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE,
                  5'd0,  1'b0, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE};
        pv[2] = '{8'h25, 5'd31, 1'b1, 32'h8000_0000, 1'b0, 32'hAAAA_0000, 32'h0000_5555,
                  5'd31, 1'b1, 32'h8000_0000, 1'b0, 32'hAAAA_0000, 32'h0000_5555};

        mv[0] = '{OP_LB,  32'h103, 32'h0, 32'h0000_00F0, 0, 32'h100, 4'b0001, 1'b0, 32'h0, 32'hFFFF_FFF0, 1'b1, 2};
        mv[1] = '{OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 0, 32'h100, 4'b0001, 1'b0, 32'h0, 32'h0000_00F0, 1'b1, 2};
        mv[2] = '{OP_SH,  32'h202, 32'hAAAA_1234, 32'h0, 3, 32'h200, 4'b0011, 1'b1, 32'h1234_1234, 32'h0, 1'b0, 5};
        mv[3] = '{OP_LH,  32'h010, 32'h0, 32'h8001_7FFF, 1, 32'h010, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001, 1'b1, 3};
        mv[4] = '{OP_LHU, 32'h012, 32'h0, 32'h8001_F00D, 0, 32'h010, 4'b0011, 1'b0, 32'h0, 32'h0000_F00D, 1'b1, 2};
        mv[5] = '{OP_LB,  32'h101, 32'h0, 32'h127F_3456, 2, 32'h100, 4'b0100, 1'b0, 32'h0, 32'h0000_007F, 1'b1, 4};
        mv[6] = '{OP_SB,  32'h101, 32'h0000_00CC, 32'h0, 1, 32'h100, 4'b0100, 1'b1, 32'hCCCC_CCCC, 32'h0, 1'b0, 3};
        mv[7] = '{OP_SW,  32'h300, 32'hCAFE_F00D, 32'h0, 0, 32'h300, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 2};
        mv[8] = '{OP_LW,  32'h040, 32'h0, 32'hDEAD_BEEF, 0, 32'h040, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 2};
        mv[9] = '{OP_LW,  32'h044, 32'h0, 32'h0123_4567, 1, 32'h044, 4'b1111, 1'b0, 32'h0, 32'h0123_4567, 1'b1, 3};

        // Reset with a live ALU result and a load presented.
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
        drive_nop();
        mem_aluop = 8'h20; mem_rw = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'hFFFF_FFFF;
        mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2;
        next_cycle();
        next_cycle();
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_wb_wreg_rw", {26'd0, wb_wreg, wb_rw}, 32'd0);
        chk("rst_wb_hilo", {31'd0, wb_whilo} | wb_hi | wb_lo, 32'd0);
        mem_aluop = OP_LW;
        #1;
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        drive_nop();
        next_cycle();
        rst = 1'b0;

        // Pass-through ops; a stray ack in IDLE must not start anything.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            mem_aluop = pv[i].op; mem_rw = pv[i].rw; mem_wreg = pv[i].wreg;
            mem_wdata = pv[i].wdata; mem_whilo = pv[i].whilo;
            mem_hi = pv[i].hi; mem_lo = pv[i].lo;
            mem_addr = 32'h0000_0003; mem_sdata = 32'h1111_1111;
            bus_ack = 1'b1;
            #1;
            chk("pt_rw", {27'd0, wb_rw}, {27'd0, pv[i].e_rw});
            chk("pt_wreg", {31'd0, wb_wreg}, {31'd0, pv[i].e_wreg});
            chk("pt_wdata", wb_wdata, pv[i].e_wdata);
            chk("pt_whilo", {31'd0, wb_whilo}, {31'd0, pv[i].e_whilo});
            chk("pt_hi", wb_hi, pv[i].e_hi);
            chk("pt_lo", wb_lo, pv[i].e_lo);
            chk("pt_stallreq", {31'd0, stallreq}, 32'd0);
            next_cycle();
            chk("pt_bus_req", {31'd0, bus_req}, 32'd0);
        end
        bus_ack = 1'b0;
        drive_nop();

        // Memory transactions, issued back to back.
        for (int i = 0; i < 10; i++) run_mem(mv[i]);
        next_cycle();
        drive_nop();

        // Reset while BUSY; the ack one cycle later must be ignored.
        next_cycle();
        mem_aluop = OP_LW; mem_addr = 32'h80; mem_rw = 5'd3; mem_wreg = 1'b1;
        next_cycle();
        chk("mrst_busy_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("mrst_wb", {26'd0, wb_wreg, wb_rw}, 32'd0);
        next_cycle();
        drive_nop();
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        #1;
        chk("mrst_req_cleared", {31'd0, bus_req}, 32'd0);
        chk("mrst_wb_wdata", wb_wdata, 32'd0);
        next_cycle();
        rst = 1'b0; bus_ack = 1'b0;
        #1;
        chk("mrst_idle_req", {31'd0, bus_req}, 32'd0);
        chk("mrst_idle_stall", {31'd0, stallreq}, 32'd0);
        chk("mrst_wb_wreg", {31'd0, wb_wreg}, 32'd0);

`ifdef MISALIGN_CHECK_EN
        // Misaligned word load is flagged and suppressed.
        next_cycle();
        mem_aluop = OP_LW; mem_addr = 32'h42; mem_rw = 5'd4; mem_wreg = 1'b1;
        #1;
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_stall", {31'd0, stallreq}, 32'd0);
        chk("mis_wreg", {31'd0, wb_wreg}, 32'd0);
        next_cycle();
        chk("mis_no_req", {31'd0, bus_req}, 32'd0);
        drive_nop();
        #1;
        chk("mis_flag_clear", {31'd0, misalign}, 32'd0);
`else
        // Misaligned word load is forced aligned and runs normally.
        ma = '{OP_LW, 32'h042, 32'h0, 32'h600D_CAFE, 0, 32'h040, 4'b1111, 1'b0, 32'h0, 32'h600D_CAFE, 1'b1, 2};
        run_mem(ma);
        chk("mis_flag_tied", {31'd0, misalign}, 32'd0);
        next_cycle();
        drive_nop();
`endif

        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
